// File: rtl/sys_defs.sv
// Shared definitions for the fetch side of the IF->IB interface.
//   XLEN             : PC / instruction width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   IF_IB_PACKET     : one instruction slot handed to the instruction buffer
//   FETCH_STATE      : fetch controller states
//   block_addr()     : 8-byte aligned block address of a PC
package sys_defs;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] PC;
  } IF_IB_PACKET;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } FETCH_STATE;

  function automatic logic [XLEN-1:0] block_addr(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/fetch_slot_align.sv
// Turns one held 8-byte instruction block into the two-slot packet pair.
//   hold_pc    in  : PC of the first instruction to deliver from the block
//   hold_data  in  : block data, [31:0] = word at +0, [63:32] = word at +4
//   hold_valid in  : slots may be presented this cycle
//   slots      out : pair of IF_IB_PACKETs; every field of an invalid slot is 0
module fetch_slot_align
  import sys_defs::IF_IB_PACKET;
(
  input  logic [sys_defs::XLEN-1:0] hold_pc,
  input  logic [63:0]               hold_data,
  input  logic                      hold_valid,
  output IF_IB_PACKET               slots [0:1]
);

  always_comb begin
    slots[0] = '0;
    slots[1] = '0;
    if (hold_valid) begin
      slots[0].valid = 1'b1;
      slots[0].PC    = hold_pc;
      slots[0].NPC   = hold_pc + 32'd4;
      // A start PC in the upper half of the block only has one usable word.
      if (hold_pc[2]) begin
        slots[0].inst = hold_data[63:32];
      end else begin
        slots[0].inst  = hold_data[31:0];
        slots[1].valid = 1'b1;
        slots[1].PC    = hold_pc + 32'd4;
        slots[1].NPC   = hold_pc + 32'd8;
        slots[1].inst  = hold_data[63:32];
      end
    end
  end

endmodule

// File: rtl/fetch_pair_unit.sv
// Fetch producer for the instruction buffer. Requests 8-byte aligned blocks
// from instruction memory (one request outstanding at most), holds the
// returned block and presents it as a two-slot packet pair.
//   clock, reset      : clock, asynchronous active-high reset
//   squash, squash_pc : redirect from the back end (highest priority)
//   ib_ready          : buffer accepts a pair this cycle
//   if_ib_packet      : pair to the buffer, combinational from the hold register
//   proc2Imem_req/addr: memory request and aligned block address
//   Imem2proc_gnt     : request accepted
//   Imem2proc_valid/data : memory response
//   fetch_pc          : current fetch PC (debug)
module fetch_pair_unit
  import sys_defs::IF_IB_PACKET, sys_defs::FETCH_STATE,
         sys_defs::REQ, sys_defs::WAIT, sys_defs::HOLD;
#(
  parameter int              XLEN     = sys_defs::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = sys_defs::RESET_PC_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            squash,
  input  logic [XLEN-1:0] squash_pc,
  input  logic            ib_ready,
  output IF_IB_PACKET     if_ib_packet [0:1],
  output logic            proc2Imem_req,
  output logic [XLEN-1:0] proc2Imem_addr,
  input  logic            Imem2proc_gnt,
  input  logic            Imem2proc_valid,
  input  logic [63:0]     Imem2proc_data,
  output logic [XLEN-1:0] fetch_pc
);

  FETCH_STATE      state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic [XLEN-1:0] blk;
  logic            hold_valid, hold_valid_nxt;
  logic            drop_pending, drop_nxt;
  logic            hold_load;
  logic            req;
  logic            slot_en;
  logic [XLEN-1:0] hold_pc;
  logic [63:0]     hold_data;

  assign blk = {pc[XLEN-1:3], 3'b000};

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hold_valid_nxt = hold_valid;
    drop_nxt       = drop_pending;
    hold_load      = 1'b0;
    req            = 1'b0;

    case (state)
      REQ: begin
        // While a squashed response is still owed, stay quiet so that the
        // single outstanding-request rule holds.
        req = !drop_pending;
        if (drop_pending && Imem2proc_valid) drop_nxt = 1'b0;
        if (req && Imem2proc_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (Imem2proc_valid) begin
          hold_load      = 1'b1;
          hold_valid_nxt = 1'b1;
          state_nxt      = HOLD;
        end
      end
      HOLD: begin
        if (ib_ready) begin
          pc_nxt         = blk + 32'd8;
          hold_valid_nxt = 1'b0;
          state_nxt      = REQ;
        end
      end
      default: state_nxt = REQ;
    endcase

    if (squash) begin
      pc_nxt         = squash_pc;
      hold_valid_nxt = 1'b0;
      hold_load      = 1'b0;
      state_nxt      = REQ;
      // A granted request whose data has not arrived yet must be swallowed
      // when it eventually returns. A response arriving this very cycle is
      // simply not latched, so nothing is owed.
      if ((state == WAIT && !Imem2proc_valid) ||
          (state == REQ && req && Imem2proc_gnt))
        drop_nxt = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= REQ;
      pc           <= RESET_PC;
      hold_valid   <= 1'b0;
      drop_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      hold_valid   <= hold_valid_nxt;
      drop_pending <= drop_nxt;
    end
  end

  // Hold register: data only, qualified by hold_valid.
  always_ff @(posedge clock) begin
    if (hold_load) begin
      hold_data <= Imem2proc_data;
      hold_pc   <= pc;
    end
  end

  // The buffer only writes when it is not full, so slots are shown valid only
  // on the cycle the pair is actually taken.
  assign slot_en = hold_valid & ib_ready & ~squash;

  fetch_slot_align u_align (
    .hold_pc   (hold_pc),
    .hold_data (hold_data),
    .hold_valid(slot_en),
    .slots     (if_ib_packet)
  );

  assign proc2Imem_req  = req & ~reset;
  assign proc2Imem_addr = blk;
  assign fetch_pc       = pc;

endmodule

// File: tb/tb_fetch_pair_unit.sv
module tb_fetch_pair_unit;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset, squash, ib_ready, gnt, mvalid;
  logic [31:0] squash_pc;
  logic [63:0] mdata;

  IF_IB_PACKET pkt [0:1];
  IF_IB_PACKET pkt_w [0:1];
  logic        req, req_w;
  logic [31:0] addr, addr_w, fpc, fpc_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  fetch_pair_unit dut (
    .clock(clock), .reset(reset), .squash(squash), .squash_pc(squash_pc),
    .ib_ready(ib_ready), .if_ib_packet(pkt), .proc2Imem_req(req),
    .proc2Imem_addr(addr), .Imem2proc_gnt(gnt), .Imem2proc_valid(mvalid),
    .Imem2proc_data(mdata), .fetch_pc(fpc)
  );

  fetch_pair_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clock(clock), .reset(reset), .squash(squash), .squash_pc(squash_pc),
    .ib_ready(ib_ready), .if_ib_packet(pkt_w), .proc2Imem_req(req_w),
    .proc2Imem_addr(addr_w), .Imem2proc_gnt(gnt), .Imem2proc_valid(mvalid),
    .Imem2proc_data(mdata), .fetch_pc(fpc_w)
  );

  // Instruction memory contents: every word is a scramble of its address.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] align8(input logic [31:0] a);
    return a & 32'hFFFF_FFF8;
  endfunction

  function automatic logic [63:0] blk_of(input logic [31:0] a);
    logic [31:0] b;
    b = align8(a);
    return {word_at(b + 32'd4), word_at(b)};
  endfunction

  // Expected slot i when the fetch stream is at pc: the stream delivers the
  // word at pc and, when pc is the first word of a block, also the next one.
  function automatic IF_IB_PACKET exp_slot(input logic [31:0] pc, input int i);
    IF_IB_PACKET p;
    p = '0;
    if (i == 0) begin
      p.valid = 1'b1; p.PC = pc; p.inst = word_at(pc); p.NPC = pc + 32'd4;
    end else if (!pc[2]) begin
      p.valid = 1'b1; p.PC = pc + 32'd4; p.inst = word_at(pc + 32'd4);
      p.NPC = pc + 32'd8;
    end
    return p;
  endfunction

  task automatic idle();
    squash = 1'b0; gnt = 1'b0; mvalid = 1'b0; mdata = '0; ib_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete block: grant, response, optional stall, delivery.
  task automatic fetch_block(input logic [31:0] pc, input int stall, input string tag);
    idle(); gnt = 1'b1; #1;
    n_checks++;
    if (req !== 1'b1 || addr !== align8(pc)) begin
      n_fail++; $display("FAIL %s_req: got req=%b addr=%h want req=1 addr=%h", tag, req, addr, align8(pc));
    end
    tick();
    gnt = 1'b0; mvalid = 1'b1; mdata = blk_of(pc); #1;
    n_checks++;
    if (req !== 1'b0 || pkt[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_wait: got req=%b v0=%b want req=0 v0=0", tag, req, pkt[0].valid);
    end
    tick();
    mvalid = 1'b0; mdata = '0;
    for (int s = 0; s < stall; s++) begin
      ib_ready = 1'b0; #1;
      n_checks++;
      if (pkt[0] !== IF_IB_PACKET'(0) || pkt[1] !== IF_IB_PACKET'(0) || req !== 1'b0 || fpc !== pc) begin
        n_fail++; $display("FAIL %s_stall: got p0=%h p1=%h req=%b pc=%h want zeros req=0 pc=%h", tag, pkt[0], pkt[1], req, fpc, pc);
      end
      tick();
    end
    ib_ready = 1'b1; #1;
    n_checks++;
    if (pkt[0] !== exp_slot(pc, 0) || pkt[1] !== exp_slot(pc, 1) || req !== 1'b0) begin
      n_fail++; $display("FAIL %s_pair: got p0=%h p1=%h req=%b want p0=%h p1=%h req=0", tag, pkt[0], pkt[1], req, exp_slot(pc, 0), exp_slot(pc, 1));
    end
    tick();
    ib_ready = 1'b0; #1;
    n_checks++;
    if (fpc !== align8(pc) + 32'd8) begin
      n_fail++; $display("FAIL %s_nextpc: got %h want %h", tag, fpc, align8(pc) + 32'd8);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); squash_pc = '0;
    tick(); tick();
    n_checks++;
    if (req !== 1'b0 || req_w !== 1'b0 || pkt[0] !== IF_IB_PACKET'(0) || pkt[1] !== IF_IB_PACKET'(0)) begin
      n_fail++; $display("FAIL reset_outputs: got req=%b req_w=%b p0=%h p1=%h want all 0", req, req_w, pkt[0], pkt[1]);
    end
    n_checks++;
    if (fpc !== 32'h0 || fpc_w !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL reset_pc: got %h/%h want 00000000/fffffff8", fpc, fpc_w);
    end
    reset = 1'b0; #1;
    n_checks++;
    if (req_w !== 1'b1 || addr_w !== 32'hFFFF_FFF8) begin
      n_fail++; $display("FAIL reset_wrap_req: got req=%b addr=%h want 1 fffffff8", req_w, addr_w);
    end
  endtask

  task automatic test_basic();
    fetch_block(32'h0, 0, "basic0");
    n_checks++;
    if (req_w !== 1'b1 || addr_w !== 32'h0) begin
      n_fail++; $display("FAIL wrap_reset_pc_next: got req=%b addr=%h want 1 00000000", req_w, addr_w);
    end
    fetch_block(32'h8, 0, "basic8");
    fetch_block(32'h10, 0, "basic10");
  endtask

  task automatic test_misaligned();
    idle(); squash = 1'b1; squash_pc = 32'h104; #1;
    n_checks++;
    if (pkt[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL mis_squash_v: got %b want 0", pkt[0].valid);
    end
    tick();
    fetch_block(32'h104, 0, "mis104");
    fetch_block(32'h108, 0, "mis108");
  endtask

  task automatic test_stall();
    fetch_block(32'h110, 5, "stall");
  endtask

  task automatic test_squash_wait();
    idle(); gnt = 1'b1; tick();
    gnt = 1'b0; squash = 1'b1; squash_pc = 32'h200; #1;
    n_checks++;
    if (pkt[0].valid !== 1'b0 || req !== 1'b0) begin
      n_fail++; $display("FAIL sqw_squash: got v0=%b req=%b want 0 0", pkt[0].valid, req);
    end
    tick();
    idle(); ib_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin mvalid = 1'b1; mdata = blk_of(32'h118); end
      #1;
      n_checks++;
      if (req !== 1'b0 || pkt[0] !== IF_IB_PACKET'(0) || fpc !== 32'h200) begin
        n_fail++; $display("FAIL sqw_drop%0d: got req=%b p0=%h pc=%h want req=0 p0=0 pc=200", c, req, pkt[0], fpc);
      end
      tick();
    end
    fetch_block(32'h200, 0, "sqw200");
  endtask

  task automatic test_squash_req_gnt();
    idle(); gnt = 1'b1; squash = 1'b1; squash_pc = 32'h300; #1;
    n_checks++;
    if (req !== 1'b1) begin
      n_fail++; $display("FAIL sqg_req: got %b want 1", req);
    end
    tick();
    idle(); #1;
    n_checks++;
    if (req !== 1'b0) begin
      n_fail++; $display("FAIL sqg_quiet: got req=%b want 0", req);
    end
    tick();
    mvalid = 1'b1; mdata = blk_of(32'h208); ib_ready = 1'b1; #1;
    n_checks++;
    if (req !== 1'b0 || pkt[0].valid !== 1'b0) begin
      n_fail++; $display("FAIL sqg_stale: got req=%b v0=%b want 0 0", req, pkt[0].valid);
    end
    tick();
    fetch_block(32'h300, 0, "sqg300");
  endtask

  task automatic test_squash_valid();
    idle(); gnt = 1'b1; tick();
    gnt = 1'b0; mvalid = 1'b1; mdata = blk_of(32'h308); ib_ready = 1'b1;
    squash = 1'b1; squash_pc = 32'h40C; #1;
    n_checks++;
    if (pkt[0].valid !== 1'b0 || pkt[1].valid !== 1'b0) begin
      n_fail++; $display("FAIL sqv_valid: got %b %b want 0 0", pkt[0].valid, pkt[1].valid);
    end
    tick();
    fetch_block(32'h40C, 0, "sqv40c");
  endtask

  task automatic test_squash_hold();
    idle(); gnt = 1'b1; tick();
    gnt = 1'b0; mvalid = 1'b1; mdata = blk_of(32'h410); tick();
    idle(); ib_ready = 1'b1; squash = 1'b1; squash_pc = 32'h500; #1;
    n_checks++;
    if (pkt[0] !== IF_IB_PACKET'(0) || pkt[1] !== IF_IB_PACKET'(0)) begin
      n_fail++; $display("FAIL sqh_pair: got %h %h want 0 0", pkt[0], pkt[1]);
    end
    tick();
    fetch_block(32'h500, 0, "sqh500");
  endtask

  task automatic test_wrap();
    idle(); squash = 1'b1; squash_pc = 32'hFFFF_FFF8; tick();
    fetch_block(32'hFFFF_FFF8, 0, "wrap_f8");
    fetch_block(32'h0, 0, "wrap_0");
    idle(); squash = 1'b1; squash_pc = 32'hFFFF_FFFC; tick();
    fetch_block(32'hFFFF_FFFC, 0, "wrap_fc");
  endtask

  task automatic test_reset_mid();
    idle(); gnt = 1'b1; tick();
    gnt = 1'b0; reset = 1'b1; #1;
    n_checks++;
    if (req !== 1'b0 || fpc !== 32'h0 || pkt[0] !== IF_IB_PACKET'(0)) begin
      n_fail++; $display("FAIL rstmid: got req=%b pc=%h p0=%h want 0 0 0", req, fpc, pkt[0]);
    end
    tick();
    reset = 1'b0;
    fetch_block(32'h0, 0, "rstmid0");
  endtask

  task automatic test_random();
    logic [31:0] model_pc, resp_addr, tmp;
    logic        busy, emitted;
    int          cnt, pairs;
    model_pc = 32'h8; busy = 1'b0; cnt = 0; pairs = 0; resp_addr = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      idle();
      squash = ($urandom_range(0, 31) == 0);
      tmp = $urandom();
      squash_pc = {tmp[31:2], 2'b00};
      ib_ready = ($urandom_range(0, 3) != 0);
      if (busy && cnt == 0) begin mvalid = 1'b1; mdata = blk_of(resp_addr); end
      #1;
      if (req) begin
        n_checks++;
        if (busy || addr !== align8(model_pc)) begin
          n_fail++; $display("FAIL rnd_req c%0d: got addr=%h busy=%b want addr=%h busy=0", cyc, addr, busy, align8(model_pc));
        end
      end
      gnt = req && ($urandom_range(0, 3) != 0);
      #1;
      emitted = pkt[0].valid;
      n_checks++;
      if (emitted === 1'b1) begin
        if (!ib_ready || squash || pkt[0] !== exp_slot(model_pc, 0) || pkt[1] !== exp_slot(model_pc, 1)) begin
          n_fail++; $display("FAIL rnd_pair c%0d: got p0=%h p1=%h rdy=%b sq=%b want p0=%h p1=%h", cyc, pkt[0], pkt[1], ib_ready, squash, exp_slot(model_pc, 0), exp_slot(model_pc, 1));
        end
        pairs++;
      end else if (pkt[0] !== IF_IB_PACKET'(0) || pkt[1] !== IF_IB_PACKET'(0)) begin
        n_fail++; $display("FAIL rnd_idle c%0d: got p0=%h p1=%h want 0 0", cyc, pkt[0], pkt[1]);
      end
      tick();
      if (squash) model_pc = squash_pc;
      else if (emitted === 1'b1) model_pc = align8(model_pc) + 32'd8;
      if (mvalid) busy = 1'b0;
      else if (busy) cnt--;
      if (gnt) begin busy = 1'b1; resp_addr = addr; cnt = $urandom_range(0, 2); end
    end
    n_checks++;
    if (pairs < 30) begin
      n_fail++; $display("FAIL rnd_progress: got %0d pairs want at least 30", pairs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_misaligned();
    test_stall();
    test_squash_wait();
    test_squash_req_gnt();
    test_squash_valid();
    test_squash_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
